knn_dist_sort: RTL



---
 rtl/knn_pkg.sv | 18 +
 rtl/knn_sq_dist.sv | 54 +++++
 rtl/knn_dist_sort.sv | 137 +++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared widths, sentinels and state encoding for the KNN sort stage
package knn_pkg;

   localparam int COORD_W = 16;
   localparam int DIST_W  = 2*COORD_W + 1;
   localparam int IDX_W   = 7;

   localparam logic [DIST_W-1:0] DIST_MAX = '1;
   localparam logic [IDX_W-1:0]  IDX_NONE = '1;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_ACCUM = 4'b0010,
      ST_DRAIN = 4'b0100,
      ST_DONE  = 4'b1000
   } state_t;

endpackage

// File: rtl/knn_sq_dist.sv
// rtl/knn_sq_dist.sv - two-stage squared Euclidean distance pipeline with valid/idx sideband
module knn_sq_dist #(
   parameter int COORD_W = knn_pkg::COORD_W,
   parameter int DIST_W  = 2*COORD_W + 1,
   parameter int IDX_W   = knn_pkg::IDX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [2*COORD_W-1:0] test_pt,
   input  logic [2*COORD_W-1:0] data_pt,
   input  logic [IDX_W-1:0]     in_idx,
   output logic                 s1_valid,
   output logic                 out_valid,
   output logic [IDX_W-1:0]     out_idx,
   output logic [DIST_W-1:0]    out_dist
);

   logic [COORD_W-1:0] xt, yt, xd, yd;
   logic [COORD_W-1:0] dx_c, dy_c, dx_q, dy_q;
   logic [IDX_W-1:0]   idx_q;
   logic [DIST_W-1:0]  dx_sq, dy_sq;

   assign {yt, xt} = test_pt;
   assign {yd, xd} = data_pt;
   assign dx_c = (xt >= xd) ? (xt - xd) : (xd - xt);
   assign dy_c = (yt >= yd) ? (yt - yd) : (yd - yt);

   // Operands are widened first so the squares and their sum never truncate.
   assign dx_sq = DIST_W'(dx_q) * DIST_W'(dx_q);
   assign dy_sq = DIST_W'(dy_q) * DIST_W'(dy_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         dx_q      <= '0;
         dy_q      <= '0;
         idx_q     <= '0;
         out_idx   <= '0;
         out_dist  <= '0;
      end else begin
         s1_valid  <= in_valid;
         dx_q      <= dx_c;
         dy_q      <= dy_c;
         idx_q     <= in_idx;
         out_valid <= s1_valid && !flush;
         out_idx   <= idx_q;
         out_dist  <= dx_sq + dy_sq;
      end
   end

endmodule

// File: rtl/knn_dist_sort.sv
// rtl/knn_dist_sort.sv - KNN distance stage keeping a sorted list of the K nearest points
module knn_dist_sort #(
   parameter int WDATA_W = 32,
   parameter int COORD_W = WDATA_W/2,
   parameter int K       = 10,
   parameter int NUM_PTS = 128,
   parameter int IDX_W   = $clog2(NUM_PTS),
   parameter int DIST_W  = 2*COORD_W + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [WDATA_W-1:0]   test_pt_i,
   input  logic [WDATA_W-1:0]   data_pt_i,
   output logic                 busy_o,
   output logic                 valid_o,
   output logic [K*IDX_W-1:0]   nn_idx_o,
   output logic [K*DIST_W-1:0]  nn_dist_o
);

   knn_pkg::state_t state, state_nxt;

   logic [IDX_W:0]      pidx;
   logic                restart, accept, pipe_busy;
   logic [IDX_W-1:0]    samp_idx;
   logic                s1_valid, ins_valid;
   logic [IDX_W-1:0]    ins_idx;
   logic [DIST_W-1:0]   ins_dist;
   logic [K-1:0]        lt;

   logic [IDX_W-1:0]    idx_q  [K];
   logic [DIST_W-1:0]   dist_q [K];
   logic [IDX_W-1:0]    idx_n  [K];
   logic [DIST_W-1:0]   dist_n [K];

   // Any start outside ACCUM opens a new run whose first beat is index 0.
   assign restart  = start_i && (state != knn_pkg::ST_ACCUM);
   assign samp_idx = restart ? '0 : pidx[IDX_W-1:0];
   assign accept   = start_i && (restart || (pidx < (IDX_W+1)'(NUM_PTS)));

   knn_sq_dist #(
      .COORD_W (COORD_W),
      .DIST_W  (DIST_W),
      .IDX_W   (IDX_W)
   ) u_sq_dist (
      .clk       (clk),
      .rst       (rst),
      .flush     (restart),
      .in_valid  (accept),
      .test_pt   (test_pt_i),
      .data_pt   (data_pt_i),
      .in_idx    (samp_idx),
      .s1_valid  (s1_valid),
      .out_valid (ins_valid),
      .out_idx   (ins_idx),
      .out_dist  (ins_dist)
   );

   assign pipe_busy = s1_valid || ins_valid;

   always_comb begin
      state_nxt = state;
      case (state)
         knn_pkg::ST_ACCUM: if (!start_i) state_nxt = knn_pkg::ST_DRAIN;
         knn_pkg::ST_DRAIN: begin
            if (start_i)        state_nxt = knn_pkg::ST_ACCUM;
            else if (!pipe_busy) state_nxt = knn_pkg::ST_DONE;
         end
         default:           if (start_i) state_nxt = knn_pkg::ST_ACCUM;
      endcase
   end

   // Strict less-than keeps earlier indices ahead on ties; the list is sorted so lt is a thermometer.
   always_comb begin
      lt = '0;
      for (int j = 0; j < K; j++) lt[j] = ins_valid && (ins_dist < dist_q[j]);
   end

   always_comb begin
      idx_n[0]  = idx_q[0];
      dist_n[0] = dist_q[0];
      if (lt[0]) begin
         idx_n[0]  = ins_idx;
         dist_n[0] = ins_dist;
      end
      for (int j = 1; j < K; j++) begin
         idx_n[j]  = idx_q[j];
         dist_n[j] = dist_q[j];
         if (lt[j-1]) begin
            idx_n[j]  = idx_q[j-1];
            dist_n[j] = dist_q[j-1];
         end else if (lt[j]) begin
            idx_n[j]  = ins_idx;
            dist_n[j] = ins_dist;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= knn_pkg::ST_IDLE;
         valid_o <= 1'b0;
         pidx    <= '0;
         for (int j = 0; j < K; j++) begin
            idx_q[j]  <= '1;
            dist_q[j] <= '1;
         end
      end else begin
         state <= state_nxt;
         if (restart) begin
            pidx    <= (IDX_W+1)'(1);
            valid_o <= 1'b0;
            for (int j = 0; j < K; j++) begin
               idx_q[j]  <= '1;
               dist_q[j] <= '1;
            end
         end else begin
            if (start_i && (pidx < (IDX_W+1)'(NUM_PTS))) pidx <= pidx + 1'b1;
            if (state == knn_pkg::ST_DRAIN && state_nxt == knn_pkg::ST_DONE) valid_o <= 1'b1;
            if (ins_valid) begin
               for (int j = 0; j < K; j++) begin
                  idx_q[j]  <= idx_n[j];
                  dist_q[j] <= dist_n[j];
               end
            end
         end
      end
   end

   assign busy_o = (state == knn_pkg::ST_ACCUM) || (state == knn_pkg::ST_DRAIN);

   for (genvar g = 0; g < K; g++) begin : g_out
      assign nn_idx_o[g*IDX_W +: IDX_W]    = idx_q[g];
      assign nn_dist_o[g*DIST_W +: DIST_W] = dist_q[g];
   end

endmodule
